mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder_ram.sv | 31 +++
 rtl/mem_responder.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder request/response memory block.
package mem_responder_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned WAIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [BUS_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [BE_W-1:0]       be;
  } req_t;

  // Saturating increment for the statistics counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bus between a CPU (master) and mem_responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [BUS_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [BE_W-1:0]       req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_responder_ram.sv
// Synchronous single-port word RAM with per-byte write enables (read-first, no reset).
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [BE_W-1:0]       i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE/WAIT/RESP FSM, address decode and RAM access.
// Optional statistics counters are enabled by defining MEM_RESPONDER_STATS_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  state_e              r_state;
  state_e              w_next;
  logic [WAIT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]   w_cnt_next;
  req_t                r_req;
  req_t                w_acc;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic                r_rsp_load;
  logic                w_accept;
  logic                w_access;
  logic                w_err;
  logic [DATA_W-1:0]   w_ram_rdata;

  // Gated by rst_n so nothing can reach the RAM while reset is held
  assign w_accept = bus.req_valid & r_req_ready & rst_n;

  // Live request when accessing straight from IDLE, latched copy otherwise
  always_comb begin
    w_acc = r_req;
    if (r_state == IDLE) begin
      w_acc.write = bus.req_write;
      w_acc.addr  = bus.req_addr;
      w_acc.wdata = bus.req_wdata;
      w_acc.be    = bus.req_be;
    end
  end

  always_comb begin
    w_err = (w_acc.addr[1:0] != 2'b00) || ((w_acc.addr >> (ADDR_WIDTH + 2)) != '0);
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_access   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next   = RESP;
            w_access = 1'b1;
          end else begin
            w_next     = WAIT;
            w_cnt_next = WAIT_W'(WAIT_CYCLES - 32'd1);
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next   = RESP;
          w_access = 1'b1;
        end else begin
          w_cnt_next = r_cnt - WAIT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_next == IDLE);
      r_rsp_valid <= (w_next == RESP);
      if (w_accept) r_req <= w_acc;
      if (w_access) begin
        r_rsp_err  <= w_err;
        r_rsp_load <= ~w_acc.write & ~w_err;
      end else if (w_next == IDLE) begin
        r_rsp_err  <= 1'b0;
        r_rsp_load <= 1'b0;
      end
    end
  end

  mem_responder_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_access & ~w_err),
    .i_we    (w_acc.write ? w_acc.be : '0),
    .i_addr  (w_acc.addr[ADDR_WIDTH+1:2]),
    .i_wdata (w_acc.wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  // RAM output register holds the load word; masked to zero for stores and errors
  assign bus.rsp_rdata = r_rsp_load ? w_ram_rdata : '0;

`ifdef MEM_RESPONDER_STATS_EN
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_access) begin
      if (w_err)            r_err_cnt <= sat_inc(r_err_cnt);
      else if (w_acc.write) r_wr_cnt  <= sat_inc(r_wr_cnt);
      else                  r_rd_cnt  <= sat_inc(r_rd_cnt);
    end
  end

  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;
  assign err_count = r_err_cnt;
`endif

endmodule
